// File: rtl/fetch_pkg.sv
// Shared widths, reset PC and the prefetch entry type for the instruction fetch stage.
package fetch_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 6;

  localparam logic [ADDR_W-1:0] RESET_PC = 8'h00;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage : fetch_pkg

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: ROM address/data, redirect request and the decode-side valid/ready handshake.
interface instr_fetch_if;
  import fetch_pkg::*;

  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr_data;
  logic [ADDR_W-1:0]  instr_pc;

  // master is the fetch stage; slave is the ROM plus decode/branch side.
  modport master (
    output imem_addr, instr_valid, instr_data, instr_pc,
    input  imem_data, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_addr, instr_valid, instr_data, instr_pc,
    output imem_data, redirect_valid, redirect_pc, instr_ready
  );

endinterface : instr_fetch_if

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of {pc, instr} entries; flush dominates push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  fetch_entry_t               push_data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output fetch_entry_t               head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal only because the same-cycle pop frees the head slot.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; an entry is never read before it is written, and count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule : fetch_fifo

// File: rtl/instr_fetch.sv
// Fetch stage: owns the fetch PC, addresses the combinational ROM and queues fetched words for decode.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              push, pop;
  logic              fifo_full, fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  fetch_entry_t      fetch_entry, head;

  assign bus.imem_addr = pc_q;

  assign pop  = bus.instr_valid & bus.instr_ready;
  assign push = ~bus.redirect_valid & (~fifo_full | pop);

  assign fetch_entry = '{pc: pc_q, instr: bus.imem_data};

  // Redirect wins over the sequential increment; PC wraps modulo 2^ADDR_W.
  always_comb begin
    pc_d = pc_q;
    if (bus.redirect_valid) pc_d = bus.redirect_pc;
    else if (push)          pc_d = pc_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (fetch_entry),
    .pop_i       (pop),
    .flush_i     (bus.redirect_valid),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign bus.instr_valid = ~fifo_empty;
  assign bus.instr_data  = fifo_empty ? '0 : head.instr;
  assign bus.instr_pc    = fifo_empty ? '0 : head.pc;

  assert property (@(posedge clk) disable iff (!rst_n) fifo_empty == (fifo_count == '0));

endmodule : instr_fetch
